sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The module SHALL have parameter ADDR_LEN, default 10, meaning log2 of storage depth; DEPTH = 2**ADDR_LEN entries.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits.
REQ-003 The module SHALL have parameter FWFT, default 0, meaning 0 = registered-read mode and 1 = first-word-fall-through mode.
REQ-004 The module SHALL have parameter ALM_FULL_TH, default 4, meaning alm_full_o asserts when level >= DEPTH-ALM_FULL_TH.
REQ-005 The module SHALL have parameter ALM_EMPTY_TH, default 4, meaning alm_empty_o asserts when level <= ALM_EMPTY_TH.
REQ-006 The module SHALL have the following ports, one per line:
- clk  in  1  single clock, all logic on posedge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- clr_i  in  1  synchronous flush.
- d_i  in  DATA_WIDTH  write data.
- enq_i  in  1  enqueue request.
- full_o  out  1  no free entry.
- alm_full_o  out  1  almost full.
- q_o  out  DATA_WIDTH  read data.
- deq_i  in  1  dequeue request.
- empty_o  out  1  no readable entry.
- alm_empty_o  out  1  almost empty.
- level_o  out  ADDR_LEN+1  stored entry count, 0..DEPTH.
- overflow_o  out  1  sticky: enqueue attempted while full.
- underflow_o  out  1  sticky: dequeue attempted while empty.

Function
REQ-007 Pointers SHALL be ADDR_LEN+1 bits binary; the MSB distinguishes full from empty; wrap from DEPTH-1 to 0 SHALL occur naturally by modulo arithmetic.
REQ-008 A write SHALL be accepted iff enq_i && !full_o; a read SHALL be accepted iff deq_i && !empty_o.
REQ-009 When full, enq_i SHALL be rejected even if a read is accepted in the same cycle; overflow_o SHALL set.
REQ-010 When empty, deq_i SHALL be ignored; underflow_o SHALL set. Overflow and underflow SHALL clear only on reset or clr_i.
REQ-011 Simultaneous accepted write and read SHALL leave level_o unchanged.
REQ-012 level_o, full_o, empty_o, alm_full_o and alm_empty_o SHALL be registered outputs computed from the next-state level, so they are exact in the cycle after the causing edge.
REQ-013 Storage SHALL be a single-write, single-read synchronous RAM (registered read address) inferable as block RAM.
REQ-014 FWFT=0: a write accepted at edge N SHALL clear empty_o after edge N; a read accepted at edge N SHALL present data on q_o after edge N and hold it until the next accepted read.
REQ-015 FWFT=1: q_o SHALL show the head word whenever !empty_o; a read SHALL pop it, and the next word SHALL appear on q_o after the same edge with no bubble while level_o > 1.
REQ-016 FWFT=1: a write into an empty FIFO at edge N SHALL clear empty_o and validate q_o after edge N+1. level_o SHALL count the output-stage word. full_o SHALL assert at level_o == DEPTH.
REQ-017 clr_i SHALL have priority over enq_i and deq_i, and SHALL produce the reset state on the next edge; RAM contents are don't-care.

Reset
REQ-018 While rst_n_i is low, state SHALL be forced asynchronously: pointers 0, level_o 0, empty_o 1, alm_empty_o 1, full_o 0, alm_full_o 0, overflow_o 0, underflow_o 0, q_o 0.
REQ-019 Reset deassertion SHALL be synchronised by the integrator; the first accepted write SHALL be possible on the first edge after release.
REQ-020 Reset asserted mid-transfer SHALL discard all entries; no partial state SHALL survive.

Verification
REQ-021 Test: ADDR_LEN=2, FWFT=0, write 4 words 0xA0..0xA3 -> full_o=1, level_o=4; a 5th enqueue is rejected and overflow_o=1; 4 reads return 0xA0..0xA3 in order, one cycle latency; then empty_o=1.
REQ-022 Test: FWFT=1, one write 0x55 into empty -> empty_o=0 and q_o=0x55 two edges later; deq_i pops it -> empty_o=1, level_o=0.
REQ-023 Test: hold enq_i=deq_i=1 for 3*DEPTH cycles at level_o=2 -> level_o stays 2, pointers wrap 3 times, and data order is preserved.
REQ-024 Test: ALM_FULL_TH=1, ALM_EMPTY_TH=1, ADDR_LEN=2 -> alm_empty_o=1 at levels 0..1; alm_full_o=1 at levels 3..4.
REQ-025 Test: deq_i on empty -> underflow_o=1 and level_o unchanged; clr_i with enq_i=1 at level 3 -> level_o=0, empty_o=1, flags 0.
REQ-026 Test: assert rst_n_i low between clock edges at level 2 -> outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO on a registered-read RAM; q_o updates one edge after an accepted read (FWFT=0) or tracks the head word (FWFT=1).
// enq_i is refused while full_o and deq_i while empty_o; refused requests only raise the sticky overflow/underflow flags.
module sync_fifo #(
  parameter int ADDR_LEN     = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int FWFT         = 0,
  parameter int ALM_FULL_TH  = 4,
  parameter int ALM_EMPTY_TH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  input  logic                  enq_i,
  output logic                  full_o,
  output logic                  alm_full_o,
  output logic [DATA_WIDTH-1:0] q_o,
  input  logic                  deq_i,
  output logic                  empty_o,
  output logic                  alm_empty_o,
  output logic [ADDR_LEN:0]     level_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);
  localparam int DEPTH  = 1 << ADDR_LEN;
  localparam int AF_INT = DEPTH - ALM_FULL_TH;
  localparam logic [ADDR_LEN:0] DEPTH_LVL = DEPTH[ADDR_LEN:0];
  localparam logic [ADDR_LEN:0] AF_LVL    = AF_INT[ADDR_LEN:0];
  localparam logic [ADDR_LEN:0] AE_LVL    = ALM_EMPTY_TH[ADDR_LEN:0];
  localparam logic [ADDR_LEN:0] PTR_ONE   = {{ADDR_LEN{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_LEN:0]     wr_ptr, rd_ptr, ram_cnt, level_nxt;
  logic                  do_wr, do_rd, fetch, head_vld, head_vld_nxt, empty_nxt;

  always_comb begin
    do_wr        = enq_i && !full_o;
    do_rd        = deq_i && !empty_o;
    ram_cnt      = wr_ptr - rd_ptr;
    fetch        = do_rd;
    head_vld_nxt = 1'b0;
    // FWFT: refill the head register from RAM whenever it is empty or being popped.
    if (FWFT != 0) begin
      fetch        = (ram_cnt != '0) && (!head_vld || do_rd);
      head_vld_nxt = fetch || (head_vld && !do_rd);
    end
    level_nxt = level_o + (ADDR_LEN+1)'(do_wr) - (ADDR_LEN+1)'(do_rd);
    empty_nxt = (FWFT != 0) ? !head_vld_nxt : (level_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[ADDR_LEN-1:0]] <= d_i;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_o         <= '0;
      head_vld    <= 1'b0;
      level_o     <= '0;
      full_o      <= 1'b0;
      alm_full_o  <= 1'b0;
      empty_o     <= 1'b1;
      alm_empty_o <= 1'b1;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (clr_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_o         <= '0;
      head_vld    <= 1'b0;
      level_o     <= '0;
      full_o      <= 1'b0;
      alm_full_o  <= 1'b0;
      empty_o     <= 1'b1;
      alm_empty_o <= 1'b1;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (fetch) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        q_o    <= mem[rd_ptr[ADDR_LEN-1:0]];
      end
      head_vld    <= head_vld_nxt;
      level_o     <= level_nxt;
      full_o      <= (level_nxt == DEPTH_LVL);
      alm_full_o  <= (level_nxt >= AF_LVL);
      empty_o     <= empty_nxt;
      alm_empty_o <= (level_nxt <= AE_LVL);
      if (enq_i && full_o)  overflow_o  <= 1'b1;
      if (deq_i && empty_o) underflow_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: instance a is registered-read, instance b is first-word-fall-through, both depth 4.
module tb_sync_fifo;
  localparam int AL = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr_a = 1'b0, enq_a = 1'b0, deq_a = 1'b0;
  logic clr_b = 1'b0, enq_b = 1'b0, deq_b = 1'b0;
  logic [DW-1:0] d_a = '0, d_b = '0;
  logic full_a, afull_a, empty_a, aempty_a, ovf_a, unf_a;
  logic full_b, afull_b, empty_b, aempty_b, ovf_b, unf_b;
  logic [DW-1:0] q_a, q_b;
  logic [AL:0] level_a, level_b;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_b[$];
  logic pend_a = 1'b0;

  always #5 clk = ~clk;

  sync_fifo #(.ADDR_LEN(AL), .DATA_WIDTH(DW), .FWFT(0), .ALM_FULL_TH(1), .ALM_EMPTY_TH(1)) u_a (
    .clk(clk), .rst_n_i(rst_n), .clr_i(clr_a), .d_i(d_a), .enq_i(enq_a), .full_o(full_a),
    .alm_full_o(afull_a), .q_o(q_a), .deq_i(deq_a), .empty_o(empty_a), .alm_empty_o(aempty_a),
    .level_o(level_a), .overflow_o(ovf_a), .underflow_o(unf_a));

  sync_fifo #(.ADDR_LEN(AL), .DATA_WIDTH(DW), .FWFT(1), .ALM_FULL_TH(1), .ALM_EMPTY_TH(1)) u_b (
    .clk(clk), .rst_n_i(rst_n), .clr_i(clr_b), .d_i(d_b), .enq_i(enq_b), .full_o(full_b),
    .alm_full_o(afull_b), .q_o(q_b), .deq_i(deq_b), .empty_o(empty_b), .alm_empty_o(aempty_b),
    .level_o(level_b), .overflow_o(ovf_b), .underflow_o(unf_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_lvl(input bit b, input string nm, input int lvl, input bit emp);
    chk({nm, ".level"},  b ? 32'(level_b) : 32'(level_a), 32'(lvl));
    chk({nm, ".empty"},  b ? empty_b  : empty_a,  emp);
    chk({nm, ".full"},   b ? full_b   : full_a,   lvl == 4);
    chk({nm, ".afull"},  b ? afull_b  : afull_a,  lvl >= 3);
    chk({nm, ".aempty"}, b ? aempty_b : aempty_a, lvl <= 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a pops one edge after an accepted read; b is checked while the head is offered and taken.
  initial forever begin
    @(negedge clk);
    if (pend_a) begin
      if (exp_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a.read: got 0x%0h, want no data", q_a);
      end else chk("a.read", q_a, exp_a.pop_front());
    end
    pend_a = rst_n && !clr_a && deq_a && !empty_a;
    if (rst_n && !clr_b && deq_b && !empty_b) begin
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b.read: got 0x%0h, want no data", q_b);
      end else chk("b.read", q_b, exp_b.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst.q_a", q_a, 0); chk("rst.ovf_a", ovf_a, 0); chk("rst.unf_a", unf_a, 0);
    chk("rst.q_b", q_b, 0);
    chk_lvl(0, "rst_a", 0, 1);
    chk_lvl(1, "rst_b", 0, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // a: fill to full, refused fifth write, drain in order, then underflow
    enq_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_a = 8'(32'hA0 + i); exp_a.push_back(d_a);
      tick();
      chk_lvl(0, "fill_a", i + 1, 0);
    end
    d_a = 8'hEE;
    tick();
    chk("ovf_a", ovf_a, 1);
    chk_lvl(0, "ovf_a", 4, 0);
    enq_a = 1'b0; deq_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_lvl(0, "drain_a", 3 - i, (3 - i) == 0);
    end
    tick();
    deq_a = 1'b0;
    chk("unf_a", unf_a, 1);
    chk("ovf_a.sticky", ovf_a, 1);
    chk_lvl(0, "unf_a", 0, 1);

    // a: flush at level 3 with a concurrent enqueue
    enq_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_a = 8'(32'hB0 + i);
      tick();
    end
    chk_lvl(0, "preclr_a", 3, 0);
    clr_a = 1'b1; d_a = 8'hCC;
    tick();
    clr_a = 1'b0; enq_a = 1'b0;
    chk_lvl(0, "clr_a", 0, 1);
    chk("clr.ovf_a", ovf_a, 0); chk("clr.unf_a", unf_a, 0); chk("clr.q_a", q_a, 0);

    // a: streaming at level 2 across three pointer wraps
    enq_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d_a = 8'(32'hC0 + i); exp_a.push_back(d_a);
      tick();
    end
    deq_a = 1'b1;
    for (int i = 0; i < 12; i++) begin
      d_a = 8'(32'hC2 + i); exp_a.push_back(d_a);
      tick();
      chk("stream_a.level", level_a, 2);
    end
    enq_a = 1'b0;
    tick(); tick();
    deq_a = 1'b0;
    chk_lvl(0, "stream_end_a", 0, 1);

    // b: single word falls through two edges after the write
    enq_b = 1'b1; d_b = 8'h55; exp_b.push_back(d_b);
    tick();
    enq_b = 1'b0;
    chk("fwft.empty_n", empty_b, 1);
    chk("fwft.level_n", level_b, 1);
    tick();
    chk("fwft.empty_n1", empty_b, 0);
    chk("fwft.q_n1", q_b, 8'h55);
    deq_b = 1'b1;
    tick();
    deq_b = 1'b0;
    chk_lvl(1, "fwft_pop", 0, 1);

    // b: streaming at level 2, no bubble on q_o
    enq_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d_b = 8'(32'hD0 + i); exp_b.push_back(d_b);
      tick();
    end
    chk_lvl(1, "prestream_b", 2, 0);
    deq_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      d_b = 8'(32'hD2 + i); exp_b.push_back(d_b);
      tick();
      chk("stream_b.level", level_b, 2);
      chk("stream_b.empty", empty_b, 0);
    end
    enq_b = 1'b0;
    tick(); tick();
    deq_b = 1'b0;
    chk_lvl(1, "stream_end_b", 0, 1);

    // b: fill to DEPTH counting the head word, overflow, drain, underflow
    enq_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_b = 8'(32'hE0 + i); exp_b.push_back(d_b);
      tick();
      chk_lvl(1, "fill_b", i + 1, i == 0);
    end
    d_b = 8'hEE;
    tick();
    chk("ovf_b", ovf_b, 1);
    chk_lvl(1, "ovf_b", 4, 0);
    enq_b = 1'b0; deq_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_lvl(1, "drain_b", 3 - i, (3 - i) == 0);
    end
    tick();
    deq_b = 1'b0;
    chk("unf_b", unf_b, 1);

    // both: asynchronous reset between edges at level 2
    enq_a = 1'b1; d_a = 8'hF0; exp_a.push_back(d_a);
    enq_b = 1'b1; d_b = 8'h90;
    tick();
    d_a = 8'hF1; d_b = 8'h91;
    tick();
    enq_b = 1'b0; d_a = 8'hF2;
    tick();
    enq_a = 1'b0; deq_a = 1'b1;
    tick();
    deq_a = 1'b0;
    chk_lvl(0, "prerst_a", 2, 0);
    chk_lvl(1, "prerst_b", 2, 0);
    chk("prerst.q_b", q_b, 8'h90);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.q_a", q_a, 0); chk("arst.ovf_a", ovf_a, 0); chk("arst.unf_a", unf_a, 0);
    chk("arst.q_b", q_b, 0); chk("arst.ovf_b", ovf_b, 0); chk("arst.unf_b", unf_b, 0);
    chk_lvl(0, "arst_a", 0, 1);
    chk_lvl(1, "arst_b", 0, 1);

    // first write accepted on the first edge after release
    @(negedge clk);
    rst_n = 1'b1;
    enq_a = 1'b1; d_a = 8'h77; exp_a.push_back(d_a);
    tick();
    enq_a = 1'b0;
    chk_lvl(0, "post_rst_a", 1, 0);
    deq_a = 1'b1;
    tick();
    deq_a = 1'b0;
    chk_lvl(0, "post_rd_a", 0, 1);
    tick(); tick();
    chk("sb_a.left", exp_a.size(), 0);
    chk("sb_b.left", exp_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
